fusion_unit: RTL and testbench
==============================

# fusion_unit

Parametrised, pipelined bit-fusion multiply-accumulate unit. Two W-bit operand words are split into 2-, 4- or 8-bit elements according to a per-group precision mode. The elementwise products are summed as a dot product using an array of 2x2-bit bitbricks, and the result is accumulated over a multi-beat group. It replaces the fixed 4-bit quarter-level fused multiplier as the PE datapath of the systolic array, and adds three things: runtime precision, valid/ready flow control and accumulation.

## Interface
- W, 8, operand word width; legal values 4 or 8.
- ACC_W, 32, accumulator/result width; must be ≥ 2W+2.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_a, in_b  in  W  packed operand elements; element k occupies bits [k*p +: p]
- in_sa, in_sb  in  1  operand a / b elements are signed two's complement
- in_mode  in  2  00 = 2-bit, 01 = 4-bit, 10 = 8-bit (legal only when W=8), 11 = reserved
- in_first  in  1  beat opens a group; mode and sign flags are sampled here
- in_last  in  1  beat closes a group; result is emitted
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_data  out  ACC_W  signed accumulated dot product
- out_err  out  1  group used an illegal mode

## Operation
- Element width p = 2 << mode; element count n = W/p. Beat value = Σ_{k<n} a_k·b_k.
  - a_k is signed iff sa; b_k is signed iff sb.
  - Each product is exact (2p+1 bits); the sum is sign-extended to ACC_W.
- Group state: mode, sa and sb are latched on a beat with in_first and held until in_last. Values on those inputs during non-first beats are ignored.
- Accumulator:
  - A first beat loads the beat value (it does not add to the old total).
  - Other beats add with two's-complement wrap at ACC_W.
  - A beat with in_first && in_last is a single-beat group.
  - A beat without in_first that arrives after a completed group starts a new group: accumulator from 0, latched mode and sign flags retained.
- Illegal mode (11, or 10 with W=4):
  - The beat value is forced to 0.
  - A sticky group error is set, reported on out_err with the result, and cleared at the next first beat.
- Bricks: W/2 × W/2 array. Brick (i,j) multiplies a[2i+1:2i] by b[2j+1:2j].
  - The brick's sign flags are asserted only on the top crumb of its element (sa/sb gated per mode).
  - A brick contributes only when crumbs i and j belong to the same element index k, with left shift 2·((i mod p/2)+(j mod p/2)).
  - All other bricks are masked to 0.

## Timing
- Stages:
  - S1: operand/control register.
  - S2: brick products (bitbrick output register).
  - S3: shift-add tree register.
  - S4: accumulator plus output register.
- Latency: a last beat accepted at edge k gives out_valid high from edge k+4.
- Throughput: one beat per cycle; back-to-back groups need no bubble.
- Stall:
  - stall = out_valid && !out_ready && (S3 holds a last beat).
  - While stalled, all stages hold and in_ready = 0; otherwise in_ready = 1.
  - Non-last beats keep flowing into the accumulator while a result waits.
- Output handshake:
  - out_data and out_err stay stable while out_valid && !out_ready.
  - out_valid drops the cycle after acceptance unless a new result lands on the same edge, in which case it stays high with the new data.
- Reset, including mid-group:
  - All stage valids, out_valid, out_data, out_err and the accumulator go to 0.
  - Latched mode goes to 00 and sign flags to 0.
  - In-flight beats are discarded.
  - in_ready = 1 from the first edge after rst deasserts.

## Structure
- fusion_pkg holds:
  - mode_e enum (MODE_2B, MODE_4B, MODE_8B, MODE_RSVD);
  - function elem_width(mode_e);
  - brick shift/mask constant functions parameterised by W.
- Sub-module: the existing bitbrick (2-bit × 2-bit with sign flags, registered output), generated W/2 × W/2 times.
- The shift-add tree and the accumulator/handshake logic stay inline in fusion_unit.

## Test plan
- W=8, mode 10, sa=sb=1, a=8'h80, b=8'h7F, first+last → out_data = 32'hFFFFC080 (−16256) exactly 4 edges after acceptance, out_err = 0.
- Mode 01, unsigned, a=b=8'hFF, first+last → 450 (0x1C2). Same beat with sa=sb=1 → 2 (2×(−1·−1)).
- Mode 00, sa=1, sb=0, a=8'hFF, b=8'h55 → −4 (32'hFFFFFFFC). Mode 00 unsigned, same operands → 12.
- Three-beat group, mode 10 unsigned, 255×255 each → single out_valid pulse, 195075 (0x2FA03). Back-to-back next group starts from 0.
- out_ready held low across two completed groups:
  - in_ready drops once the second last beat reaches S3;
  - the first result is held stable;
  - after out_ready rises, both results arrive in order with none lost.
- Mode 11 group of 2 beats → out_data = 0, out_err = 1; next legal group → out_err = 0.
- rst pulsed after 2 beats of a 3-beat group → out_valid stays 0, no result emitted. A fresh single-beat 3×3 (mode 10, unsigned) group yields 9.

Source files
------------

// File: rtl/fusion_pkg.sv
// fusion_pkg
// Shared types and helpers for the bit-fusion multiply-accumulate unit.
//   mode_e          : per-group element precision (2, 4 or 8 bit, plus reserved)
//   elem_width      : element width in bits for a mode
//   mode_illegal    : true for the reserved mode or an element wider than the word
//   brick_top       : crumb i is the most significant crumb of its element
//   brick_mask      : brick (i,j) pairs crumbs of the same element index
//   brick_shift     : left shift applied to brick (i,j) inside its element product
package fusion_pkg;

    typedef enum logic [1:0] {
        MODE_2B   = 2'b00,
        MODE_4B   = 2'b01,
        MODE_8B   = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    // A 2x2 brick product with optional sign extension lies in [-6, 9].
    localparam int BRICK_PROD_W = 6;

    function automatic int elem_width(mode_e m);
        return 2 << int'(m);
    endfunction

    function automatic logic mode_illegal(mode_e m, int w);
        return (m == MODE_RSVD) || (elem_width(m) > w);
    endfunction

    function automatic int crumbs_per_elem(mode_e m);
        return elem_width(m) / 2;
    endfunction

    function automatic logic brick_top(mode_e m, int i);
        int c = crumbs_per_elem(m);
        return (i % c) == (c - 1);
    endfunction

    // Cross-element bricks and every brick of an illegal mode contribute nothing.
    function automatic logic brick_mask(mode_e m, int w, int i, int j);
        int c = crumbs_per_elem(m);
        return !mode_illegal(m, w) && (i < w / 2) && (j < w / 2) && ((i / c) == (j / c));
    endfunction

    function automatic int brick_shift(mode_e m, int i, int j);
        int c = crumbs_per_elem(m);
        return 2 * ((i % c) + (j % c));
    endfunction

endpackage

// File: rtl/fusion_unit_bitbrick.sv
// bitbrick
// 2-bit x 2-bit multiplier with per-operand sign flags. Operands are
// registered on entry and the product is registered on exit, so a brick
// spans two pipeline stages; both registers hold while en is low.
//   clk, rst : clock, asynchronous active-high reset
//   en       : advance enable (low while the pipeline is stalled)
//   x, y     : operand crumbs
//   sx, sy   : treat x / y as signed two's complement
//   prod     : signed product
module bitbrick
    import fusion_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [1:0]                     x,
    input  logic [1:0]                     y,
    input  logic                           sx,
    input  logic                           sy,
    output logic signed [BRICK_PROD_W-1:0] prod
);

    logic [1:0]        x_q;
    logic [1:0]        y_q;
    logic              sx_q;
    logic              sy_q;
    logic signed [2:0] xe;
    logic signed [2:0] ye;

    // Operand capture, aligned with the control pipeline stage that feeds the bricks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q  <= '0;
            y_q  <= '0;
            sx_q <= 1'b0;
            sy_q <= 1'b0;
        end else if (en) begin
            x_q  <= x;
            y_q  <= y;
            sx_q <= sx;
            sy_q <= sy;
        end
    end

    // Top bit is replicated only when the crumb is the signed top of its element.
    assign xe = {sx_q & x_q[1], x_q};
    assign ye = {sy_q & y_q[1], y_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod <= '0;
        end else if (en) begin
            prod <= BRICK_PROD_W'(xe) * BRICK_PROD_W'(ye);
        end
    end

endmodule

// File: rtl/fusion_unit.sv
// fusion_unit
// Pipelined bit-fusion dot-product multiply-accumulate unit.
//   clk, rst           : clock, asynchronous active-high reset
//   in_valid/in_ready  : beat handshake
//   in_a, in_b         : packed operand words, element k at [k*p +: p]
//   in_sa, in_sb       : operand elements signed
//   in_mode            : 00 2-bit, 01 4-bit, 10 8-bit, 11 reserved
//   in_first, in_last  : group delimiters (mode/sign flags sampled on first)
//   out_valid/out_ready: result handshake
//   out_data           : signed accumulated dot product of the group
//   out_err            : group used an illegal mode
// Stages: S1 operand/control, S1D brick operand capture, S2 brick products,
// S3 shift-add tree, S4 accumulator and output. A last beat accepted at edge
// k presents its result from edge k+4.
module fusion_unit
    import fusion_pkg::*;
#(
    parameter int W     = 8,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_sa,
    input  logic             in_sb,
    input  logic [1:0]       in_mode,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_err
);

    localparam int HALF = W / 2;

    logic  stall;
    logic  accept;

    mode_e grp_mode;
    logic  grp_sa;
    logic  grp_sb;
    logic  grp_open;
    mode_e eff_mode;
    logic  eff_sa;
    logic  eff_sb;
    logic  eff_start;

    logic          s1_valid, s1_sa, s1_sb, s1_start, s1_last, s1_illegal;
    logic [W-1:0]  s1_a, s1_b;
    mode_e         s1_mode;

    logic          s1d_valid, s1d_start, s1d_last, s1d_illegal;
    mode_e         s1d_mode;

    logic          s2_valid, s2_start, s2_last, s2_illegal;
    mode_e         s2_mode;

    logic             s3_valid, s3_start, s3_last, s3_illegal;
    logic [ACC_W-1:0] s3_sum;

    logic [ACC_W-1:0] tree_sum;
    logic [ACC_W-1:0] acc;
    logic             acc_err;
    logic [ACC_W-1:0] acc_next;
    logic             err_next;

    logic [HALF-1:0]                brick_sx;
    logic [HALF-1:0]                brick_sy;
    logic signed [BRICK_PROD_W-1:0] brick_prod [HALF][HALF];

    // The whole pipeline freezes only when a finished result is waiting and
    // the next group's result is already at the accumulator input.
    assign stall    = out_valid && !out_ready && s3_valid && s3_last;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;

    // A beat opens a group either explicitly or by arriving after a closed
    // group; in the latter case the previously latched mode/signs carry over.
    always_comb begin
        eff_mode  = grp_mode;
        eff_sa    = grp_sa;
        eff_sb    = grp_sb;
        eff_start = in_first || !grp_open;
        if (in_first) begin
            eff_mode = mode_e'(in_mode);
            eff_sa   = in_sa;
            eff_sb   = in_sb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grp_mode <= MODE_2B;
            grp_sa   <= 1'b0;
            grp_sb   <= 1'b0;
            grp_open <= 1'b0;
        end else if (accept) begin
            if (in_first) begin
                grp_mode <= mode_e'(in_mode);
                grp_sa   <= in_sa;
                grp_sb   <= in_sb;
            end
            grp_open <= !in_last;
        end
    end

    // S1 carries resolved per-beat control so downstream stages never look
    // back at group state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_mode    <= MODE_2B;
            s1_sa      <= 1'b0;
            s1_sb      <= 1'b0;
            s1_start   <= 1'b0;
            s1_last    <= 1'b0;
            s1_illegal <= 1'b0;
        end else if (!stall) begin
            s1_valid   <= accept;
            s1_a       <= in_a;
            s1_b       <= in_b;
            s1_mode    <= eff_mode;
            s1_sa      <= eff_sa;
            s1_sb      <= eff_sb;
            s1_start   <= eff_start;
            s1_last    <= in_last;
            s1_illegal <= mode_illegal(eff_mode, W);
        end
    end

    // Control shadows for the two brick register levels and the tree register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1d_valid   <= 1'b0;
            s1d_mode    <= MODE_2B;
            s1d_start   <= 1'b0;
            s1d_last    <= 1'b0;
            s1d_illegal <= 1'b0;
            s2_valid    <= 1'b0;
            s2_mode     <= MODE_2B;
            s2_start    <= 1'b0;
            s2_last     <= 1'b0;
            s2_illegal  <= 1'b0;
            s3_valid    <= 1'b0;
            s3_sum      <= '0;
            s3_start    <= 1'b0;
            s3_last     <= 1'b0;
            s3_illegal  <= 1'b0;
        end else if (!stall) begin
            s1d_valid   <= s1_valid;
            s1d_mode    <= s1_mode;
            s1d_start   <= s1_start;
            s1d_last    <= s1_last;
            s1d_illegal <= s1_illegal;
            s2_valid    <= s1d_valid;
            s2_mode     <= s1d_mode;
            s2_start    <= s1d_start;
            s2_last     <= s1d_last;
            s2_illegal  <= s1d_illegal;
            s3_valid    <= s2_valid;
            s3_sum      <= tree_sum;
            s3_start    <= s2_start;
            s3_last     <= s2_last;
            s3_illegal  <= s2_illegal;
        end
    end

    // Brick array: row i takes crumb i of a, column j takes crumb j of b.
    for (genvar i = 0; i < HALF; i++) begin : g_row
        assign brick_sx[i] = s1_sa && brick_top(s1_mode, i);
        assign brick_sy[i] = s1_sb && brick_top(s1_mode, i);
        for (genvar j = 0; j < HALF; j++) begin : g_col
            bitbrick u_brick (
                .clk  (clk),
                .rst  (rst),
                .en   (!stall),
                .x    (s1_a[2*i +: 2]),
                .y    (s1_b[2*j +: 2]),
                .sx   (brick_sx[i]),
                .sy   (brick_sy[j]),
                .prod (brick_prod[i][j])
            );
        end
    end

    // Shift-add tree: same-element bricks are weighted by their crumb
    // positions and everything is summed into one dot-product value.
    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < HALF; i++) begin
            for (int j = 0; j < HALF; j++) begin
                if (brick_mask(s2_mode, W, i, j)) begin
                    tree_sum = tree_sum +
                        ({{(ACC_W-BRICK_PROD_W){brick_prod[i][j][BRICK_PROD_W-1]}}, brick_prod[i][j]}
                         << brick_shift(s2_mode, i, j));
                end
            end
        end
    end

    always_comb begin
        acc_next = s3_start ? s3_sum : acc + s3_sum;
        err_next = s3_start ? s3_illegal : (acc_err | s3_illegal);
    end

    // Accumulator and output register. Non-last beats may update the
    // accumulator while an earlier result is still waiting on the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            acc_err   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else if (!stall) begin
            if (s3_valid) begin
                acc     <= acc_next;
                acc_err <= err_next;
            end
            if (s3_valid && s3_last) begin
                out_valid <= 1'b1;
                out_data  <= acc_next;
                out_err   <= err_next;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fusion_unit.sv
// tb_fusion_unit
// Directed self-checking bench for fusion_unit (W=8, ACC_W=32). Each step
// drives one or more beats and compares outputs with hand-computed values.
module tb_fusion_unit;

    localparam int W     = 8;
    localparam int ACC_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             in_sa;
    logic             in_sb;
    logic [1:0]       in_mode;
    logic             in_first;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_err;

    int checks = 0;
    int errors = 0;

    fusion_unit #(.W(W), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sa     (in_sa),
        .in_sb     (in_sb),
        .in_mode   (in_mode),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    // Absolute backstop in case a bounded wait is somehow bypassed.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [ACC_W-1:0] observed,
                               input logic [ACC_W-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Present one beat and return #1 after the edge that accepted it.
    task automatic applyStimulus(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [1:0] mode, input logic sa, input logic sb,
                                 input logic first, input logic last);
        int   tries = 0;
        logic taken = 1'b0;
        in_a     = a;
        in_b     = b;
        in_mode  = mode;
        in_sa    = sa;
        in_sb    = sb;
        in_first = first;
        in_last  = last;
        in_valid = 1'b1;
        while (!taken && tries < 50) begin
            taken = in_ready;
            tick();
            tries++;
        end
        checkOutput({tag, "_accepted"}, {31'd0, taken}, 32'd1);
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid; edges counts clock edges waited.
    task automatic waitResult(input string tag, output int edges);
        edges = 0;
        while (!out_valid && edges < 20) begin
            tick();
            edges++;
        end
        checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic runSingle(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [1:0] mode, input logic sa, input logic sb,
                             input logic [ACC_W-1:0] exp_data, input logic exp_err);
        int edges;
        applyStimulus(tag, a, b, mode, sa, sb, 1'b1, 1'b1);
        waitResult(tag, edges);
        checkOutput({tag, "_data"}, out_data, exp_data);
        checkOutput({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
        tick();
    endtask

    initial begin
        int               edges;
        int               seen;
        logic [ACC_W-1:0] results [$];

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sa     = 1'b0;
        in_sb     = 1'b0;
        in_mode   = 2'b00;
        in_first  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out_data", out_data, 32'd0);
        checkOutput("rst_out_err", {31'd0, out_err}, 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // 8-bit signed, latency check: -128 * 127
        applyStimulus("m8_signed", 8'h80, 8'h7F, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1);
        waitResult("m8_signed", edges);
        checkOutput("m8_signed_latency", edges, 32'd4);
        checkOutput("m8_signed_data", out_data, 32'hFFFFC080);
        checkOutput("m8_signed_err", {31'd0, out_err}, 32'd0);
        tick();
        checkOutput("m8_signed_drop", {31'd0, out_valid}, 32'd0);

        // 4-bit: 15*15*2 unsigned, (-1*-1)*2 signed
        runSingle("m4_unsigned", 8'hFF, 8'hFF, 2'b01, 1'b0, 1'b0, 32'd450, 1'b0);
        runSingle("m4_signed", 8'hFF, 8'hFF, 2'b01, 1'b1, 1'b1, 32'd2, 1'b0);

        // 2-bit: four (-1*1) mixed-sign, four (3*1) unsigned
        runSingle("m2_mixed", 8'hFF, 8'h55, 2'b00, 1'b1, 1'b0, 32'hFFFFFFFC, 1'b0);
        runSingle("m2_unsigned", 8'hFF, 8'h55, 2'b00, 1'b0, 1'b0, 32'd12, 1'b0);

        // Three-beat group (middle-beat mode ignored) then a back-to-back group
        applyStimulus("grp3_b0", 8'hFF, 8'hFF, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus("grp3_b1", 8'hFF, 8'hFF, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus("grp3_b2", 8'hFF, 8'hFF, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus("b2b", 8'h12, 8'h34, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) begin
            if (out_valid) results.push_back(out_data);
            tick();
        end
        checkOutput("grp3_pulses", results.size(), 32'd2);
        checkOutput("grp3_data", (results.size() > 0) ? results[0] : 32'hDEAD_BEEF, 32'h0002FA03);
        checkOutput("b2b_data", (results.size() > 1) ? results[1] : 32'hDEAD_BEEF, 32'd11);

        // Back-pressure across two completed groups
        out_ready = 1'b0;
        applyStimulus("bp_a", 8'h11, 8'h22, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus("bp_b", 8'h33, 8'h11, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        checkOutput("bp_ready_before", {31'd0, in_ready}, 32'd1);
        checkOutput("bp_valid_before", {31'd0, out_valid}, 32'd0);
        tick();
        checkOutput("bp_stall_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("bp_first_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("bp_first_data", out_data, 32'd4);
        tick();
        tick();
        tick();
        checkOutput("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("bp_hold_data", out_data, 32'd4);
        out_ready = 1'b1;
        tick();
        checkOutput("bp_second_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("bp_second_data", out_data, 32'd6);
        checkOutput("bp_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        checkOutput("bp_drain", {31'd0, out_valid}, 32'd0);

        // Reserved mode group, then a legal group clears the error
        applyStimulus("rsvd_b0", 8'hFF, 8'hFF, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus("rsvd_b1", 8'hFF, 8'hFF, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        waitResult("rsvd", edges);
        checkOutput("rsvd_data", out_data, 32'd0);
        checkOutput("rsvd_err", {31'd0, out_err}, 32'd1);
        tick();
        runSingle("after_rsvd", 8'h01, 8'h03, 2'b00, 1'b0, 1'b0, 32'd3, 1'b0);

        // Reset mid-group discards in-flight beats
        applyStimulus("mid_b0", 8'h10, 8'h10, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus("mid_b1", 8'h10, 8'h10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        checkOutput("mid_rst_data", out_data, 32'd0);
        checkOutput("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            tick();
        end
        checkOutput("mid_rst_no_result", seen, 32'd0);
        runSingle("fresh", 8'h03, 8'h03, 2'b10, 1'b0, 1'b0, 32'd9, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
